// File: rtl/mem_check_pkg.sv
// Shared state encoding, fail codes and sizing helper for the memory write checker.
package mem_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_DATA    = 3'd1;
  localparam logic [2:0] FC_ADDR    = 3'd2;
  localparam logic [2:0] FC_TIMEOUT = 3'd3;

  // Table index width; a one-entry table still gets a 1-bit index port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Counts enabled cycles from zero; flags the cycle in which the count sits at LIMIT-1.
module timeout_counter #(
  parameter int unsigned LIMIT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // LIMIT of zero means the run never times out.
  if (LIMIT == 0) begin : g_off
    assign o_expired = 1'b0;
  end else begin : g_on
    assign o_expired = i_enable && (r_count == CNT_W'(LIMIT - 1));
  end

endmodule

// File: rtl/mem_write_checker.sv
// Watches a CPU data-memory write port and checks it against an ordered table of
// expected (address, data) writes, reporting pass, mismatch, stray write or timeout.
module mem_write_checker
  import mem_check_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_EXP     = 1,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned IGN_LO      = 80,
  parameter int unsigned IGN_HI      = 80,
  parameter int unsigned STRICT      = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          memwrite,
  input  logic [ADDR_W-1:0]             dataadr,
  input  logic [DATA_W-1:0]             writedata,
  input  logic                          cfg_we,
  input  logic [idx_width(NUM_EXP)-1:0] cfg_idx,
  input  logic [ADDR_W-1:0]             cfg_addr,
  input  logic [DATA_W-1:0]             cfg_data,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [2:0]                    fail_code,
  output logic [ADDR_W-1:0]             fail_addr,
  output logic [DATA_W-1:0]             fail_data,
  output logic [4:0]                    match_count
);

  localparam int unsigned       IDX_W     = idx_width(NUM_EXP);
  localparam logic [ADDR_W-1:0] IGN_LO_A  = ADDR_W'(IGN_LO);
  localparam logic [ADDR_W-1:0] IGN_HI_A  = ADDR_W'(IGN_HI);
  localparam logic [4:0]        NUM_EXP_C = 5'(NUM_EXP);
  localparam logic [IDX_W:0]    NUM_EXP_I = (IDX_W + 1)'(NUM_EXP);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_exp_addr [NUM_EXP];
  logic [DATA_W-1:0] r_exp_data [NUM_EXP];
  logic [4:0]        r_match_count, w_match_count_next;
  logic [2:0]        r_fail_code, w_fail_code_next;
  logic [ADDR_W-1:0] r_fail_addr, w_fail_addr_next;
  logic [DATA_W-1:0] r_fail_data, w_fail_data_next;

  logic             w_run, w_expired, w_cfg_wr, w_ignored, w_addr_hit, w_data_hit, w_write;
  logic [IDX_W-1:0] w_rd_idx;

  assign w_run      = (r_state == ST_RUN);
  assign w_cfg_wr   = cfg_we && !w_run && ({1'b0, cfg_idx} < NUM_EXP_I);
  assign w_rd_idx   = r_match_count[IDX_W-1:0];
  assign w_ignored  = (dataadr >= IGN_LO_A) && (dataadr <= IGN_HI_A);
  assign w_addr_hit = (dataadr == r_exp_addr[w_rd_idx]);
  assign w_data_hit = (writedata == r_exp_data[w_rd_idx]);
  assign w_write    = memwrite && !w_ignored;

  // Table is deliberately not reset so a reprogram is only needed when contents change.
  always_ff @(posedge clk) begin
    if (w_cfg_wr) begin
      r_exp_addr[cfg_idx] <= cfg_addr;
      r_exp_data[cfg_idx] <= cfg_data;
    end
  end

  timeout_counter #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_enable (w_run),
    .i_clear  (!w_run),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_match_count <= '0;
      r_fail_code   <= FC_NONE;
      r_fail_addr   <= '0;
      r_fail_data   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_match_count <= w_match_count_next;
      r_fail_code   <= w_fail_code_next;
      r_fail_addr   <= w_fail_addr_next;
      r_fail_data   <= w_fail_data_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_match_count_next = r_match_count;
    w_fail_code_next   = r_fail_code;
    w_fail_addr_next   = r_fail_addr;
    w_fail_data_next   = r_fail_data;
    if (w_run) begin
      if (w_write && w_addr_hit && w_data_hit) begin
        w_match_count_next = r_match_count + 5'd1;
        if (w_match_count_next == NUM_EXP_C) begin
          w_state_next = ST_PASS;
        end
      end else if (w_write && w_addr_hit) begin
        w_state_next     = ST_FAIL;
        w_fail_code_next = FC_DATA;
        w_fail_addr_next = dataadr;
        w_fail_data_next = writedata;
      end else if (w_write && (STRICT != 0)) begin
        w_state_next     = ST_FAIL;
        w_fail_code_next = FC_ADDR;
        w_fail_addr_next = dataadr;
        w_fail_data_next = writedata;
      end
      // Timeout only fires when the write in the same cycle did not end the run.
      if ((w_state_next == ST_RUN) && w_expired) begin
        w_state_next     = ST_FAIL;
        w_fail_code_next = FC_TIMEOUT;
        w_fail_addr_next = '0;
        w_fail_data_next = '0;
      end
    end else if (start) begin
      w_state_next       = ST_RUN;
      w_match_count_next = '0;
      w_fail_code_next   = FC_NONE;
      w_fail_addr_next   = '0;
      w_fail_data_next   = '0;
    end
  end

  always_comb begin
    busy        = (r_state == ST_RUN);
    done        = (r_state == ST_PASS) || (r_state == ST_FAIL);
    pass        = (r_state == ST_PASS);
    fail_code   = r_fail_code;
    fail_addr   = r_fail_addr;
    fail_data   = r_fail_data;
    match_count = r_match_count;
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: three instances with different table depth,
// strictness and timeout; expected run outcomes are queued and checked when done rises.
module tb_mem_write_checker;

  typedef struct packed {
    logic        pass;
    logic [2:0]  fc;
    logic [31:0] fa;
    logic [31:0] fd;
    logic [4:0]  mc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  start_v = '0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic [2:0]  cfg_we_v = '0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0;

  logic        busy_v [3];
  logic        done_v [3];
  logic        pass_v [3];
  logic [2:0]  fc_v   [3];
  logic [31:0] fa_v   [3];
  logic [31:0] fd_v   [3];
  logic [4:0]  mc_v   [3];

  exp_t exp_q [$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // Instance 0: one entry, strict, 100-cycle timeout.
  mem_write_checker #(.NUM_EXP(1), .TIMEOUT_CYC(100), .STRICT(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .cfg_we(cfg_we_v[0]), .cfg_idx(cfg_idx[0:0]), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .fail_code(fc_v[0]), .fail_addr(fa_v[0]), .fail_data(fd_v[0]), .match_count(mc_v[0]));

  // Instance 1: three entries, strict, default timeout.
  mem_write_checker #(.NUM_EXP(3), .STRICT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .cfg_we(cfg_we_v[1]), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .fail_code(fc_v[1]), .fail_addr(fa_v[1]), .fail_data(fd_v[1]), .match_count(mc_v[1]));

  // Instance 2: one entry, non-strict.
  mem_write_checker #(.NUM_EXP(1), .STRICT(0)) u_dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .cfg_we(cfg_we_v[2]), .cfg_idx(cfg_idx[0:0]), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .fail_code(fc_v[2]), .fail_addr(fa_v[2]), .fail_data(fd_v[2]), .match_count(mc_v[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  task automatic cfg(input int inst, input logic [1:0] idx, input logic [31:0] a,
                     input logic [31:0] d);
    cfg_we_v[inst] = 1'b1;
    cfg_idx = idx;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we_v = '0;
  endtask

  task automatic go(input int inst);
    start_v[inst] = 1'b1;
    tick();
    start_v = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1;
    dataadr = a;
    writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic push_exp(input logic p, input logic [2:0] fc, input logic [31:0] fa,
                          input logic [31:0] fd, input logic [4:0] mc);
    exp_t e;
    e.pass = p; e.fc = fc; e.fa = fa; e.fd = fd; e.mc = mc;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for done, then pops the queued outcome and compares every field.
  task automatic check_run(input int inst, input int budget, input string tag);
    exp_t e;
    int n = 0;
    while (done_v[inst] !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    cmp({tag, "_done"}, 32'(done_v[inst]), 32'd1);
    vectors++;
    assert (exp_q.size() > 0) else begin
      miscompares++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp({tag, "_busy"}, 32'(busy_v[inst]), 32'd0);
      cmp({tag, "_pass"}, 32'(pass_v[inst]), 32'(e.pass));
      cmp({tag, "_fail_code"}, 32'(fc_v[inst]), 32'(e.fc));
      cmp({tag, "_fail_addr"}, fa_v[inst], e.fa);
      cmp({tag, "_fail_data"}, fd_v[inst], e.fd);
      cmp({tag, "_match_count"}, 32'(mc_v[inst]), 32'(e.mc));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    repeat (3) tick();
    $display("reset: checking outputs held at zero");
    cmp("rst_busy", 32'(busy_v[0]), 32'd0);
    cmp("rst_done", 32'(done_v[0]), 32'd0);
    cmp("rst_pass", 32'(pass_v[0]), 32'd0);
    cmp("rst_fail_code", 32'(fc_v[0]), 32'd0);
    cmp("rst_fail_addr", fa_v[0], 32'd0);
    cmp("rst_match_count", 32'(mc_v[1]), 32'd0);
    reset = 1'b1;
    tick();

    $display("t1: table {(84,7)}, ignored write then match");
    cfg(0, 2'd0, 32'd84, 32'd7);
    go(0);
    cmp("t1_busy", 32'(busy_v[0]), 32'd1);
    push_exp(1'b1, 3'd0, 32'd0, 32'd0, 5'd1);
    wr(32'd80, 32'd3);
    cmp("t1_ignored_busy", 32'(busy_v[0]), 32'd1);
    wr(32'd84, 32'd7);
    check_run(0, 0, "t1");

    $display("t2: data mismatch at expected address");
    go(0);
    push_exp(1'b0, 3'd1, 32'd84, 32'd6, 5'd0);
    wr(32'd84, 32'd6);
    check_run(0, 0, "t2");

    $display("t3: stray write with strict checking");
    go(0);
    cmp("t3_fail_code_cleared", 32'(fc_v[0]), 32'd0);
    cmp("t3_done_cleared", 32'(done_v[0]), 32'd0);
    push_exp(1'b0, 3'd2, 32'd88, 32'd1, 5'd0);
    wr(32'd88, 32'd1);
    check_run(0, 0, "t3");

    $display("t4: stray write with non-strict checking");
    cfg(2, 2'd0, 32'd84, 32'd7);
    go(2);
    wr(32'd88, 32'd1);
    cmp("t4_still_busy", 32'(busy_v[2]), 32'd1);
    push_exp(1'b1, 3'd0, 32'd0, 32'd0, 5'd1);
    wr(32'd84, 32'd7);
    check_run(2, 0, "t4");

    $display("t5: three-entry table, out of order then in order");
    cfg(1, 2'd0, 32'd0, 32'd1);
    cfg(1, 2'd1, 32'd4, 32'd2);
    cfg(1, 2'd2, 32'd8, 32'd3);
    go(1);
    push_exp(1'b0, 3'd2, 32'd4, 32'd2, 5'd0);
    wr(32'd4, 32'd2);
    check_run(1, 0, "t5a");
    go(1);
    push_exp(1'b1, 3'd0, 32'd0, 32'd0, 5'd3);
    wr(32'd0, 32'd1);
    cmp("t5_mc_after_first", 32'(mc_v[1]), 32'd1);
    go(1);
    cmp("t5_start_in_run_mc", 32'(mc_v[1]), 32'd1);
    cmp("t5_start_in_run_busy", 32'(busy_v[1]), 32'd1);
    wr(32'd4, 32'd2);
    wr(32'd8, 32'd3);
    check_run(1, 0, "t5b");

    $display("t6: no writes, 100-cycle timeout");
    go(0);
    n = 0;
    while (busy_v[0] === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    cmp("t6_busy_cycles", 32'(n), 32'd100);
    push_exp(1'b0, 3'd3, 32'd0, 32'd0, 5'd0);
    check_run(0, 0, "t6");

    $display("t7: matching write in the last timeout cycle wins");
    go(0);
    repeat (99) tick();
    cmp("t7_busy_before_write", 32'(busy_v[0]), 32'd1);
    push_exp(1'b1, 3'd0, 32'd0, 32'd0, 5'd1);
    wr(32'd84, 32'd7);
    check_run(0, 0, "t7");

    $display("t8: reset mid-run, table write in run ignored, restart");
    go(1);
    wr(32'd0, 32'd1);
    reset = 1'b0;
    tick();
    cmp("t8_rst_busy", 32'(busy_v[1]), 32'd0);
    cmp("t8_rst_done", 32'(done_v[1]), 32'd0);
    cmp("t8_rst_mc", 32'(mc_v[1]), 32'd0);
    cmp("t8_rst_fail_code", 32'(fc_v[1]), 32'd0);
    reset = 1'b1;
    go(1);
    cfg(1, 2'd0, 32'd0, 32'd55);
    cmp("t8_busy_after_cfg", 32'(busy_v[1]), 32'd1);
    push_exp(1'b1, 3'd0, 32'd0, 32'd0, 5'd3);
    wr(32'd0, 32'd1);
    wr(32'd4, 32'd2);
    wr(32'd8, 32'd3);
    check_run(1, 0, "t8");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
